// File: rtl/oldland_dbus_bridge.sv
// oldland_dbus_bridge: data-bus bridge between the CPU data port and on-chip
// RAM / peripheral bus. Each request is decoded in IDLE and answered with a
// single-cycle d_ack_o / d_error_o pulse in RESP. Every output is registered.
// Optional feature: define OLDLAND_DBUS_TIMEOUT_EN to abort peripheral
// accesses that get no p_ready_i / p_error_i within TIMEOUT cycles.
//
// Handshakes:
//   CPU side   - d_access_i is held stable with its address/data until the
//                bridge pulses d_ack_o or d_error_o for exactly one cycle;
//                d_access_i is ignored in that response cycle.
//   Peripheral - p_sel_o and the p_* qualifiers are held until p_ready_i or
//                p_error_i is sampled high (p_error_i wins); p_sel_o drops on
//                the following cycle.
module oldland_dbus_bridge #(
    parameter int RAM_AW      = 12,
    parameter int RAM_LATENCY = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       d_addr_i,
    input  logic [3:0]        d_bytesel_i,
    input  logic              d_wr_en_i,
    input  logic [31:0]       d_wr_val_i,
    input  logic              d_access_i,
    output logic [31:0]       d_data_o,
    output logic              d_ack_o,
    output logic              d_error_o,
    output logic              ram_cs_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wr_en_o,
    output logic [3:0]        ram_bytesel_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              p_sel_o,
    output logic [31:0]       p_addr_o,
    output logic              p_wr_en_o,
    output logic [3:0]        p_bytesel_o,
    output logic [31:0]       p_wdata_o,
    input  logic [31:0]       p_rdata_i,
    input  logic              p_ready_i,
    input  logic              p_error_i,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RAM_WAIT = 2'd1;
    localparam logic [1:0] S_P_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    // Reject out-of-range parameters at elaboration.
    if (RAM_LATENCY < 1 || RAM_LATENCY > 4 || TIMEOUT < 2 || TIMEOUT > 65535 ||
        RAM_AW < 1 || RAM_AW > 26) begin : g_bad_param
        $error("oldland_dbus_bridge: parameter out of range");
    end

    logic [1:0]        state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       d_data_q, d_data_d;
    logic              d_ack_q, d_ack_d;
    logic              d_error_q, d_error_d;
    logic              ram_cs_q, ram_cs_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic [3:0]        ram_bytesel_q, ram_bytesel_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              p_sel_q, p_sel_d;
    logic [31:0]       p_addr_q, p_addr_d;
    logic              p_wr_en_q, p_wr_en_d;
    logic [3:0]        p_bytesel_q, p_bytesel_d;
    logic [31:0]       p_wdata_q, p_wdata_d;

    logic ram_hit, p_hit, bad_req;

`ifdef OLDLAND_DBUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_d;
`endif

    // Address decode of the pending request; a request with no byte lanes is an error.
    always_comb begin
        ram_hit = (d_addr_i[31:28] == 4'h0);
        p_hit   = (d_addr_i[31:28] == 4'h8);
        bad_req = (d_bytesel_i == 4'b0000) || !(ram_hit || p_hit);
    end

    // Next-state logic: response pulses and the RAM strobe default low each cycle.
    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        is_wr_d       = is_wr_q;
        d_data_d      = 32'h0;
        d_ack_d       = 1'b0;
        d_error_d     = 1'b0;
        ram_cs_d      = 1'b0;
        ram_wr_en_d   = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_bytesel_d = ram_bytesel_q;
        ram_wdata_d   = ram_wdata_q;
        p_sel_d       = p_sel_q;
        p_addr_d      = p_addr_q;
        p_wr_en_d     = p_wr_en_q;
        p_bytesel_d   = p_bytesel_q;
        p_wdata_d     = p_wdata_q;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (d_access_i) begin
                    is_wr_d = d_wr_en_i;
                    if (bad_req) begin
                        d_error_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (ram_hit) begin
                        // Upper address bits above the RAM size alias.
                        ram_cs_d      = 1'b1;
                        ram_wr_en_d   = d_wr_en_i;
                        ram_addr_d    = d_addr_i[RAM_AW+1:2];
                        ram_bytesel_d = d_bytesel_i;
                        ram_wdata_d   = d_wr_val_i;
                        lat_d         = 3'(RAM_LATENCY);
                        state_d       = S_RAM_WAIT;
                    end else begin
                        p_sel_d     = 1'b1;
                        p_addr_d    = d_addr_i;
                        p_wr_en_d   = d_wr_en_i;
                        p_bytesel_d = d_bytesel_i;
                        p_wdata_d   = d_wr_val_i;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
                        tmo_d       = 16'h0;
`endif
                        state_d     = S_P_WAIT;
                    end
                end
            end
            S_RAM_WAIT: begin
                if (lat_q == 3'd0) begin
                    d_ack_d  = 1'b1;
                    d_data_d = is_wr_q ? 32'h0 : ram_rdata_i;
                    state_d  = S_RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_P_WAIT: begin
                if (p_error_i) begin
                    p_sel_d   = 1'b0;
                    p_wr_en_d = 1'b0;
                    d_error_d = 1'b1;
                    state_d   = S_RESP;
                end else if (p_ready_i) begin
                    p_sel_d   = 1'b0;
                    p_wr_en_d = 1'b0;
                    d_ack_d   = 1'b1;
                    d_data_d  = p_wr_en_q ? 32'h0 : p_rdata_i;
                    state_d   = S_RESP;
                end
`ifdef OLDLAND_DBUS_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    p_sel_d   = 1'b0;
                    p_wr_en_d = 1'b0;
                    d_error_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + 16'h1;
                end
`endif
            end
            S_RESP: begin
                // Turnaround cycle: the CPU drops or changes its request here.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any slave access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lat_q         <= 3'd0;
            is_wr_q       <= 1'b0;
            d_data_q      <= 32'h0;
            d_ack_q       <= 1'b0;
            d_error_q     <= 1'b0;
            ram_cs_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_bytesel_q <= 4'h0;
            ram_wdata_q   <= 32'h0;
            p_sel_q       <= 1'b0;
            p_addr_q      <= 32'h0;
            p_wr_en_q     <= 1'b0;
            p_bytesel_q   <= 4'h0;
            p_wdata_q     <= 32'h0;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
            tmo_q         <= 16'h0;
`endif
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            is_wr_q       <= is_wr_d;
            d_data_q      <= d_data_d;
            d_ack_q       <= d_ack_d;
            d_error_q     <= d_error_d;
            ram_cs_q      <= ram_cs_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_bytesel_q <= ram_bytesel_d;
            ram_wdata_q   <= ram_wdata_d;
            p_sel_q       <= p_sel_d;
            p_addr_q      <= p_addr_d;
            p_wr_en_q     <= p_wr_en_d;
            p_bytesel_q   <= p_bytesel_d;
            p_wdata_q     <= p_wdata_d;
`ifdef OLDLAND_DBUS_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign d_data_o      = d_data_q;
    assign d_ack_o       = d_ack_q;
    assign d_error_o     = d_error_q;
    assign ram_cs_o      = ram_cs_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_wr_en_o   = ram_wr_en_q;
    assign ram_bytesel_o = ram_bytesel_q;
    assign ram_wdata_o   = ram_wdata_q;
    assign p_sel_o       = p_sel_q;
    assign p_addr_o      = p_addr_q;
    assign p_wr_en_o     = p_wr_en_q;
    assign p_bytesel_o   = p_bytesel_q;
    assign p_wdata_o     = p_wdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_oldland_dbus_bridge.sv
// Testbench for oldland_dbus_bridge: directed transactions with hand-computed
// cycle numbers, a behavioural RAM of latency LAT, and a responder that drives
// p_ready / p_error in a chosen cycle.
module tb_oldland_dbus_bridge;

  localparam int LAT = 2;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d_addr, d_wr_val, d_data, ram_wdata, ram_rdata;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  d_bytesel, ram_bytesel, p_bytesel;
  logic        d_wr_en, d_access, d_ack, d_error;
  logic        ram_cs, ram_wr_en, p_sel, p_wr_en, p_ready, p_error;
  logic [11:0] ram_addr;
  logic [1:0]  dbg_state;

  oldland_dbus_bridge #(.RAM_AW(12), .RAM_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_addr_i(d_addr), .d_bytesel_i(d_bytesel), .d_wr_en_i(d_wr_en),
    .d_wr_val_i(d_wr_val), .d_access_i(d_access),
    .d_data_o(d_data), .d_ack_o(d_ack), .d_error_o(d_error),
    .ram_cs_o(ram_cs), .ram_addr_o(ram_addr), .ram_wr_en_o(ram_wr_en),
    .ram_bytesel_o(ram_bytesel), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .p_sel_o(p_sel), .p_addr_o(p_addr), .p_wr_en_o(p_wr_en),
    .p_bytesel_o(p_bytesel), .p_wdata_o(p_wdata), .p_rdata_i(p_rdata),
    .p_ready_i(p_ready), .p_error_i(p_error), .dbg_state_o(dbg_state)
  );

  // ---------------- RAM model: data valid LAT cycles after the strobe cycle ----------------
  logic [31:0] mem [4096];
  logic [31:0] rd_s1, rd_s2;
  assign ram_rdata = rd_s2;

  always @(posedge clk) begin
    rd_s1 <= (ram_cs && !ram_wr_en) ? mem[ram_addr] : 32'h0;
    rd_s2 <= rd_s1;
    if (ram_cs && ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_bytesel[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Observations of the last transaction
  int          o_resp, o_cs_first, o_cs_cnt, o_ps_first, o_ps_last, o_ps_cnt;
  logic        o_ack, o_err, o_cs_wr, o_p_wr, o_post;
  logic [31:0] o_data, o_cs_wdata, o_p_addr, o_p_wdata, o_post_data;
  logic [11:0] o_cs_addr;
  logic [3:0]  o_cs_bs;

  // ---------------- driver ----------------
  // Drives a request in cycle 0 and samples mid-cycle thereafter; the
  // peripheral responder raises p_ready / p_error for cycle rdy_cyc / err_cyc.
  task automatic txn(input logic [31:0] addr, input logic [3:0] bs, input logic wr,
                     input logic [31:0] wv, input int rdy_cyc, input int err_cyc,
                     input logic [31:0] prd);
    o_resp = -1; o_cs_first = -1; o_cs_cnt = 0; o_ps_first = -1; o_ps_last = -1;
    o_ps_cnt = 0; o_ack = 0; o_err = 0; o_cs_wr = 0; o_p_wr = 0; o_post = 0;
    o_data = 0; o_cs_wdata = 0; o_p_addr = 0; o_p_wdata = 0; o_post_data = 0;
    o_cs_addr = 0; o_cs_bs = 0;
    @(negedge clk);
    d_addr = addr; d_bytesel = bs; d_wr_en = wr; d_wr_val = wv; d_access = 1'b1;
    p_ready = 1'b0; p_error = 1'b0; p_rdata = prd;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ram_cs) begin
        if (o_cs_first < 0) o_cs_first = c;
        o_cs_cnt++;
        o_cs_addr = ram_addr; o_cs_wr = ram_wr_en; o_cs_bs = ram_bytesel; o_cs_wdata = ram_wdata;
      end
      if (p_sel) begin
        if (o_ps_first < 0) o_ps_first = c;
        o_ps_last = c;
        o_ps_cnt++;
        o_p_addr = p_addr; o_p_wr = p_wr_en; o_p_wdata = p_wdata;
      end
      if (d_ack || d_error) begin
        o_resp = c; o_ack = d_ack; o_err = d_error; o_data = d_data;
        d_access = 1'b0; p_ready = 1'b0; p_error = 1'b0;
        @(negedge clk);
        o_post = d_ack | d_error | p_sel | ram_cs;
        o_post_data = d_data;
        break;
      end
      p_ready = (c == rdy_cyc);
      p_error = (c == err_cyc);
    end
    d_access = 1'b0; p_ready = 1'b0; p_error = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    d_addr = 0; d_bytesel = 0; d_wr_en = 0; d_wr_val = 0; d_access = 0;
    p_rdata = 0; p_ready = 0; p_error = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", {31'h0, d_ack}, 32'h0);
    check("rst_err", {31'h0, d_error}, 32'h0);
    check("rst_data", d_data, 32'h0);
    check("rst_strobes", {30'h0, ram_cs, p_sel}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // RAM load, word 4
    txn(32'h0000_0010, 4'hF, 1'b0, 32'h0, -1, -1, 32'h0);
    check("rl_cs_first", o_cs_first, 1);
    check("rl_cs_cnt", o_cs_cnt, 1);
    check("rl_cs_addr", {20'h0, o_cs_addr}, 32'd4);
    check("rl_cs_wr", {31'h0, o_cs_wr}, 32'h0);
    check("rl_resp", o_resp, 2 + LAT);
    check("rl_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("rl_data", o_data, 32'hDEADBEEF);
    check("rl_pulse", {31'h0, o_post}, 32'h0);
    check("rl_post_data", o_post_data, 32'h0);

    // RAM store, partial bytes into word 2
    txn(32'h0000_0008, 4'b0011, 1'b1, 32'h1234_5678, -1, -1, 32'h0);
    check("rs_cs_first", o_cs_first, 1);
    check("rs_cs_wr", {31'h0, o_cs_wr}, 32'h1);
    check("rs_cs_bs", {28'h0, o_cs_bs}, 32'h3);
    check("rs_wdata", o_cs_wdata, 32'h1234_5678);
    check("rs_resp", o_resp, 2 + LAT);
    check("rs_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("rs_data", o_data, 32'h0);
    check("rs_mem", mem[2], 32'h0000_5678);

    // RAM alias: bit 14 lies above a 16 KiB RAM, so this is word 4 again
    txn(32'h0000_4010, 4'hF, 1'b0, 32'h0, -1, -1, 32'h0);
    check("ra_cs_addr", {20'h0, o_cs_addr}, 32'd4);
    check("ra_data", o_data, 32'hDEADBEEF);

    // Peripheral load, p_ready sampled in cycle 5
    txn(32'h8000_0004, 4'hF, 1'b0, 32'h0, 5, -1, 32'hA5A5_A5A5);
    check("pl_ps_first", o_ps_first, 1);
    check("pl_ps_last", o_ps_last, 5);
    check("pl_p_addr", o_p_addr, 32'h8000_0004);
    check("pl_resp", o_resp, 6);
    check("pl_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("pl_data", o_data, 32'hA5A5_A5A5);
    check("pl_no_cs", o_cs_cnt, 0);

    // Peripheral ready and error together: error wins
    txn(32'h8000_0008, 4'hF, 1'b0, 32'h0, 2, 2, 32'h5555_AAAA);
    check("pe_resp", o_resp, 3);
    check("pe_err", {30'h0, o_ack, o_err}, 32'h1);
    check("pe_data", o_data, 32'h0);

    // Peripheral store with the fastest response
    txn(32'h8000_0010, 4'b1100, 1'b1, 32'hCAFE_F00D, 1, -1, 32'hFFFF_FFFF);
    check("ps_wr", {31'h0, o_p_wr}, 32'h1);
    check("ps_wdata", o_p_wdata, 32'hCAFE_F00D);
    check("ps_resp", o_resp, 2);
    check("ps_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("ps_data", o_data, 32'h0);

    // Unmapped region
    txn(32'h4000_0000, 4'hF, 1'b0, 32'h0, -1, -1, 32'h0);
    check("um_resp", o_resp, 1);
    check("um_err", {30'h0, o_ack, o_err}, 32'h1);
    check("um_strobes", o_cs_cnt + o_ps_cnt, 0);

    // Empty byte enables inside the RAM region
    txn(32'h0000_0000, 4'h0, 1'b0, 32'h0, -1, -1, 32'h0);
    check("bz_resp", o_resp, 1);
    check("bz_err", {30'h0, o_ack, o_err}, 32'h1);
    check("bz_strobes", o_cs_cnt + o_ps_cnt, 0);

`ifdef OLDLAND_DBUS_TIMEOUT_EN
    // Silent peripheral times out
    txn(32'h8000_0020, 4'hF, 1'b0, 32'h0, -1, -1, 32'h0);
    check("to_ps_first", o_ps_first, 1);
    check("to_ps_last", o_ps_last, TMO);
    check("to_ps_cnt", o_ps_cnt, TMO);
    check("to_resp", o_resp, TMO + 1);
    check("to_err", {30'h0, o_ack, o_err}, 32'h1);
    // Ready in the expiry cycle beats the timeout
    txn(32'h8000_0020, 4'hF, 1'b0, 32'h0, TMO, -1, 32'h0BAD_CAFE);
    check("tr_resp", o_resp, TMO + 1);
    check("tr_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("tr_data", o_data, 32'h0BAD_CAFE);
`else
    // Without a timeout a slow peripheral is simply waited for
    txn(32'h8000_0020, 4'hF, 1'b0, 32'h0, 20, -1, 32'h0BAD_CAFE);
    check("sl_ps_last", o_ps_last, 20);
    check("sl_resp", o_resp, 21);
    check("sl_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("sl_data", o_data, 32'h0BAD_CAFE);
`endif

    // Reset in cycle 3 of a pending peripheral access
    @(negedge clk);
    d_addr = 32'h8000_0030; d_bytesel = 4'hF; d_wr_en = 1'b0; d_access = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_psel_before", {31'h0, p_sel}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_psel", {31'h0, p_sel}, 32'h0);
    check("mr_resp", {30'h0, d_ack, d_error}, 32'h0);
    check("mr_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    d_access = 1'b0;
    check("mr_hold", {28'h0, d_ack, d_error, p_sel, ram_cs}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh RAM load after reset
    txn(32'h0000_0010, 4'hF, 1'b0, 32'h0, -1, -1, 32'h0);
    check("ar_resp", o_resp, 2 + LAT);
    check("ar_ack", {30'h0, o_ack, o_err}, 32'h2);
    check("ar_data", o_data, 32'hDEADBEEF);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
